// File: rtl/req_encoder_8to3_pkg.sv
// req_encoder_8to3_pkg: shared widths and state encoding for the request encoder
package req_encoder_8to3_pkg;
  localparam int REQ_N = 8;
  localparam int REQ_W = $clog2(REQ_N);
  typedef enum logic {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_e;
endpackage

// File: rtl/req_encoder_8to3_prio_enc.sv
// prio_enc: combinational N->W priority encoder, highest set index wins, any flags a set bit
module prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = req[i] ? W'(i) : idx;
    any = |req;
  end
endmodule

// File: rtl/req_encoder_8to3.sv
// req_encoder_8to3: sticky request capture offering one pending index per cycle, highest first
module req_encoder_8to3
  import req_encoder_8to3_pkg::*;
#(
  parameter int N = REQ_N,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         ovf
);
  state_e state_q, state_d;
  logic [N-1:0] pend_q, pend_d, cand, idx_oh, hi_oh;
  logic [W-1:0] idx_q, idx_d, hi;
  logic ovf_q, ovf_d, hold, any;
  prio_enc #(.N(N), .W(W)) u_prio (.req(cand), .idx(hi), .any(any));
  always_comb begin
    cand = pend_q | req;
    idx_oh = N'(1) << idx_q;
    hi_oh = N'(1) << hi;
    hold = state_q == ST_OFFER && !out_ready;
    state_d = hold || any ? ST_OFFER : ST_IDLE;
    idx_d = !hold && any ? hi : idx_q;
    pend_d = hold ? pend_q | (req & ~idx_oh) : cand & ~hi_oh;
    ovf_d = |(req & (pend_q | (hold ? idx_oh : '0)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_valid = state_q == ST_OFFER;
  assign out_idx = idx_q;
  assign pending = pend_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_req_encoder_8to3.sv
// tb_req_encoder_8to3: directed vectors with an expected-index queue drained by an acceptance monitor
module tb_req_encoder_8to3;
  logic clk = 0, rst = 1, out_ready = 0, out_valid, ovf;
  logic [7:0] req = 8'hFF, pending;
  logic [2:0] out_idx;
  int checks = 0, failures = 0;
  logic [2:0] exp_q[$];
  req_encoder_8to3 dut (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .pending(pending), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stream_extra act=%0h exp=none", out_idx);
      end else chk("stream_idx", {29'd0, out_idx}, {29'd0, exp_q.pop_front()});
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    tick();
    chk("rst_valid0", {31'd0, out_valid}, 0);
    chk("rst_pend0", {24'd0, pending}, 0);
    chk("rst_ovf0", {31'd0, ovf}, 0);
    tick();
    chk("rst_valid1", {31'd0, out_valid}, 0);
    chk("rst_pend1", {24'd0, pending}, 0);
    chk("rst_ovf1", {31'd0, ovf}, 0);
    rst = 0;
    req = 8'h00;
    tick();
    chk("idle_valid", {31'd0, out_valid}, 0);
    out_ready = 1;
    req = 8'h20;
    exp_q.push_back(3'd5);
    tick();
    req = 8'h00;
    chk("single_valid", {31'd0, out_valid}, 1);
    chk("single_idx", {29'd0, out_idx}, 5);
    tick();
    chk("single_done", {31'd0, out_valid}, 0);
    req = 8'hFF;
    for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
    tick();
    req = 8'h00;
    chk("all_idx7", {29'd0, out_idx}, 7);
    chk("all_pend", {24'd0, pending}, 8'h7F);
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk("all_idx", {29'd0, out_idx}, i);
    end
    tick();
    chk("all_done", {31'd0, out_valid}, 0);
    out_ready = 0;
    req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    req = 8'h80;
    tick();
    req = 8'h00;
    chk("hold_idx", {29'd0, out_idx}, 0);
    chk("hold_pend", {24'd0, pending}, 8'h80);
    chk("hold_ovf", {31'd0, ovf}, 0);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd7);
    out_ready = 1;
    tick();
    chk("next_idx7", {29'd0, out_idx}, 7);
    chk("next_valid", {31'd0, out_valid}, 1);
    tick();
    chk("hold_done", {31'd0, out_valid}, 0);
    out_ready = 0;
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    req = 8'h08;
    tick();
    req = 8'h00;
    chk("ovf_set", {31'd0, ovf}, 1);
    chk("ovf_pend", {24'd0, pending}, 0);
    tick();
    chk("ovf_clear", {31'd0, ovf}, 0);
    exp_q.push_back(3'd3);
    out_ready = 1;
    tick();
    chk("ovf_single", {31'd0, out_valid}, 0);
    req = 8'h04;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd2);
    tick();
    chk("acc_idx", {29'd0, out_idx}, 2);
    tick();
    req = 8'h00;
    chk("acc_ovf", {31'd0, ovf}, 0);
    chk("acc_again", {31'd0, out_valid}, 1);
    chk("acc_idx2", {29'd0, out_idx}, 2);
    tick();
    chk("acc_done", {31'd0, out_valid}, 0);
    out_ready = 0;
    req = 8'h1C;
    tick();
    req = 8'h00;
    chk("pre_rst_idx", {29'd0, out_idx}, 4);
    chk("pre_rst_pend", {24'd0, pending}, 8'h0C);
    rst = 1;
    tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_pend", {24'd0, pending}, 0);
    rst = 0;
    out_ready = 1;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 0);
    tick();
    chk("post_rst_valid2", {31'd0, out_valid}, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
